// File: rtl/decred_regbank_pkg.sv
// ---------------------------------------------------------------------------
// decred_regbank_pkg: shared register map, CONTROL bit indices and sizes for
// the decred control register file.                               Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package decred_regbank_pkg;

  localparam int MACRO_AW      = 6;
  localparam int RD_PIPE_DEPTH = 2;
  localparam int CTRL_W        = 6;

  localparam logic [7:0] ADDR_MACRO_ADDR = 8'h00;
  localparam logic [7:0] ADDR_MACRO_DATA = 8'h01;
  localparam logic [7:0] ADDR_SEL_STAT   = 8'h02;
  localparam logic [7:0] ADDR_CONTROL    = 8'h03;
  localparam logic [7:0] ADDR_SPI_ADDR   = 8'h04;
  localparam logic [7:0] ADDR_SEL_ID     = 8'h05;
  localparam logic [7:0] ADDR_MACRO_INFO = 8'h06;
  localparam logic [7:0] ADDR_PERF0      = 8'h07;
  localparam logic [7:0] ADDR_PERF1      = 8'h08;
  localparam logic [7:0] ADDR_PERF2      = 8'h09;
  localparam logic [7:0] ADDR_PERF3      = 8'h0A;
  localparam logic [7:0] ADDR_IRQ_MASK   = 8'h0B;
  localparam logic [7:0] ADDR_IRQ_CLEAR  = 8'h0C;

  localparam int CTRL_HASH_EN  = 0;
  localparam int CTRL_AUTOINC  = 1;
  localparam int CTRL_PERF_RUN = 2;
  localparam int CTRL_LED      = 3;
  localparam int CTRL_HCLK_RST = 4;
  localparam int CTRL_ID       = 5;
  localparam int CTRL_PERF_CLR = 6;

  function automatic logic is_macro_addr(input logic [7:0] a);
    return a[7:6] == 2'b10;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decred_irq_ctrl.sv
// ---------------------------------------------------------------------------
// decred_irq_ctrl: rising-edge detect, sticky status with write-1-to-clear,
// mask and registered interrupt output.                           Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decred_irq_ctrl #(
  parameter int NUM_MACROS = 4
) (
  input  logic                  M1_CLK,
  input  logic                  RST,
  input  logic [NUM_MACROS-1:0] irq_in,
  input  logic                  mask_we,
  input  logic                  clr_we,
  input  logic [NUM_MACROS-1:0] wdata,
  output logic [NUM_MACROS-1:0] status,
  output logic [NUM_MACROS-1:0] mask,
  output logic                  irq_out
);

  logic [NUM_MACROS-1:0] r_irq_d;
  logic [NUM_MACROS-1:0] r_status;
  logic [NUM_MACROS-1:0] r_mask;
  logic                  r_irq;
  logic [NUM_MACROS-1:0] w_rise;
  logic [NUM_MACROS-1:0] w_clr;

  assign w_rise = irq_in & ~r_irq_d;
  assign w_clr  = clr_we ? wdata : '0;

  always_ff @(posedge M1_CLK) begin
    if (RST) begin
      r_irq_d  <= '0;
      r_status <= '0;
      r_mask   <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_irq_d  <= irq_in;
      // a new edge in the same cycle as its clear keeps the bit set
      r_status <= (r_status & ~w_clr) | w_rise;
      if (mask_we) r_mask <= wdata;
      r_irq    <= |(r_status & r_mask);
    end
  end

  assign status  = r_status;
  assign mask    = r_mask;
  assign irq_out = r_irq;

endmodule

`default_nettype wire

// File: rtl/decred_ctrl_regfile.sv
// ---------------------------------------------------------------------------
// decred_ctrl_regfile: host register bank and hash-macro sequencer with a
// two-stage read pipeline. Optional perf counter: DECRED_PERF_CTR_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decred_ctrl_regfile
  import decred_regbank_pkg::*;
#(
  parameter int         NUM_MACROS = 4,
  parameter int         DATA_WIDTH = 8,
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] ID_VALUE   = 8'h12
) (
  input  logic                  M1_CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic                  host_wr,
  input  logic                  host_rd,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  output logic                  macro_hash_en,
  output logic [NUM_MACROS-1:0] macro_wr_sel,
  output logic [NUM_MACROS-1:0] macro_rd_sel,
  output logic [MACRO_AW-1:0]   macro_addr,
  output logic [DATA_WIDTH-1:0] macro_wdata,
  input  logic [DATA_WIDTH-1:0] macro_rdata,
  input  logic [NUM_MACROS-1:0] macro_irq,
  output logic                  led_out,
  output logic                  hash_clock_reset,
  output logic                  id_out,
  output logic [6:0]            spi_addr,
  output logic                  irq_out
);

  logic [MACRO_AW-1:0]      r_maddr;
  logic [NUM_MACROS-1:0]    r_rd_sel;
  logic [NUM_MACROS-1:0]    r_wr_sel;
  logic [CTRL_W-1:0]        r_ctrl;
  logic [7:0]               r_spi_addr;
  logic                     r_wr_act;
  logic [NUM_MACROS-1:0]    r_wr_pulse;
  logic [MACRO_AW-1:0]      r_waddr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [RD_PIPE_DEPTH-1:0] r_vld;
  logic                     r_s1_mac;
  logic [MACRO_AW-1:0]      r_s1_addr;
  logic [DATA_WIDTH-1:0]    r_s1_data;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic [DATA_WIDTH-1:0]    w_local;
  logic [NUM_MACROS-1:0]    w_irq_status;
  logic [NUM_MACROS-1:0]    w_irq_mask;
  logic                     w_rd;

  // a simultaneous write takes the slot; the read is dropped
  assign w_rd = host_rd & ~host_wr;

  always_ff @(posedge M1_CLK) begin
    if (RST) begin
      r_maddr    <= '0;
      r_rd_sel   <= '0;
      r_wr_sel   <= '0;
      r_ctrl     <= '0;
      r_spi_addr <= '0;
      r_wr_act   <= 1'b0;
      r_wr_pulse <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_wr_act   <= 1'b0;
      r_wr_pulse <= '0;
      r_wdata    <= '0;
      if (host_wr) begin
        case (host_addr)
          ADDR_MACRO_ADDR: r_maddr <= host_wdata[MACRO_AW-1:0];
          ADDR_MACRO_DATA: begin
            r_wr_act   <= 1'b1;
            r_wr_pulse <= r_wr_sel;
            r_waddr    <= r_maddr;
            r_wdata    <= host_wdata;
            if (r_ctrl[CTRL_AUTOINC]) r_maddr <= r_maddr + MACRO_AW'(1);
          end
          ADDR_SEL_STAT:   r_rd_sel   <= host_wdata[NUM_MACROS-1:0];
          ADDR_CONTROL:    r_ctrl     <= host_wdata[CTRL_W-1:0];
          ADDR_SPI_ADDR:   r_spi_addr <= host_wdata;
          ADDR_SEL_ID:     r_wr_sel   <= host_wdata[NUM_MACROS-1:0];
          default: ;
        endcase
      end
    end
  end

`ifdef DECRED_PERF_CTR_EN
  logic [31:0] r_perf;
  logic [31:0] r_snap;
  logic        w_perf_clr;

  assign w_perf_clr = host_wr && (host_addr == ADDR_CONTROL) && host_wdata[CTRL_PERF_CLR];

  always_ff @(posedge M1_CLK) begin
    if (RST) begin
      r_perf <= '0;
      r_snap <= '0;
    end else begin
      if (w_perf_clr)                 r_perf <= '0;
      else if (r_ctrl[CTRL_PERF_RUN]) r_perf <= r_perf + 32'd1;
      if (w_rd && (host_addr == ADDR_PERF0)) r_snap <= r_perf;
    end
  end
`endif

  always_comb begin
    w_local = '0;
    case (host_addr)
      ADDR_MACRO_ADDR: w_local = DATA_WIDTH'(r_maddr);
      ADDR_SEL_STAT:   w_local[NUM_MACROS-1:0] = w_irq_status;
      ADDR_CONTROL:    w_local[CTRL_W-1:0] = r_ctrl;
      ADDR_SPI_ADDR:   w_local = r_spi_addr;
      ADDR_SEL_ID:     w_local = ID_VALUE;
      ADDR_MACRO_INFO: w_local = {4'(NUM_MACROS), 4'h0};
`ifdef DECRED_PERF_CTR_EN
      ADDR_PERF0:      w_local = r_perf[7:0];
      ADDR_PERF1:      w_local = r_snap[15:8];
      ADDR_PERF2:      w_local = r_snap[23:16];
      ADDR_PERF3:      w_local = r_snap[31:24];
`else
      ADDR_PERF0, ADDR_PERF1, ADDR_PERF2, ADDR_PERF3: w_local = '0;
`endif
      ADDR_IRQ_MASK:   w_local[NUM_MACROS-1:0] = w_irq_mask;
      default: ;
    endcase
  end

  // stage 1 drives the macro bus, stage 2 presents the data
  always_ff @(posedge M1_CLK) begin
    if (RST) begin
      r_vld     <= '0;
      r_s1_mac  <= 1'b0;
      r_s1_addr <= '0;
      r_s1_data <= '0;
      r_rdata   <= '0;
    end else begin
      r_vld     <= {r_vld[RD_PIPE_DEPTH-2:0], w_rd};
      r_s1_mac  <= w_rd && is_macro_addr(host_addr);
      r_s1_addr <= host_addr[MACRO_AW-1:0];
      r_s1_data <= w_local;
      r_rdata   <= r_vld[0] ? (r_s1_mac ? macro_rdata : r_s1_data) : '0;
    end
  end

  decred_irq_ctrl #(
    .NUM_MACROS (NUM_MACROS)
  ) u_irq (
    .M1_CLK  (M1_CLK),
    .RST     (RST),
    .irq_in  (macro_irq),
    .mask_we (host_wr && (host_addr == ADDR_IRQ_MASK)),
    .clr_we  (host_wr && (host_addr == ADDR_IRQ_CLEAR)),
    .wdata   (host_wdata[NUM_MACROS-1:0]),
    .status  (w_irq_status),
    .mask    (w_irq_mask),
    .irq_out (irq_out)
  );

  assign host_rdata       = r_rdata;
  assign host_rvalid      = r_vld[RD_PIPE_DEPTH-1];
  assign macro_wr_sel     = r_wr_pulse;
  assign macro_wdata      = r_wdata;
  assign macro_rd_sel     = r_rd_sel;
  assign macro_addr       = r_wr_act ? r_waddr : (r_s1_mac ? r_s1_addr : r_maddr);
  assign macro_hash_en    = r_ctrl[CTRL_HASH_EN];
  assign led_out          = r_ctrl[CTRL_LED];
  assign hash_clock_reset = r_ctrl[CTRL_HCLK_RST];
  assign id_out           = r_ctrl[CTRL_ID];
  assign spi_addr         = r_spi_addr[6:0];

endmodule

`default_nettype wire

// File: tb/tb_decred_ctrl_regfile.sv
// ---------------------------------------------------------------------------
// tb_decred_ctrl_regfile: directed plus random stimulus against a cycle-level
// register-map model of the control register file.                Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_decred_ctrl_regfile;

  localparam int NM = 4;

  logic          M1_CLK = 1'b0;
  logic          RST;
  logic [7:0]    host_addr;
  logic [7:0]    host_wdata;
  logic          host_wr;
  logic          host_rd;
  logic [7:0]    host_rdata;
  logic          host_rvalid;
  logic          macro_hash_en;
  logic [NM-1:0] macro_wr_sel;
  logic [NM-1:0] macro_rd_sel;
  logic [5:0]    macro_addr;
  logic [7:0]    macro_wdata;
  logic [7:0]    macro_rdata;
  logic [NM-1:0] macro_irq;
  logic          led_out;
  logic          hash_clock_reset;
  logic          id_out;
  logic [6:0]    spi_addr;
  logic          irq_out;

  always #5 M1_CLK = ~M1_CLK;

  // macro array stand-in: word value is a fixed function of its address
  assign macro_rdata = {2'b00, macro_addr} ^ 8'h5A;

  decred_ctrl_regfile #(
    .NUM_MACROS (NM),
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .ID_VALUE   (8'h12)
  ) dut (
    .M1_CLK           (M1_CLK),
    .RST              (RST),
    .host_addr        (host_addr),
    .host_wdata       (host_wdata),
    .host_wr          (host_wr),
    .host_rd          (host_rd),
    .host_rdata       (host_rdata),
    .host_rvalid      (host_rvalid),
    .macro_hash_en    (macro_hash_en),
    .macro_wr_sel     (macro_wr_sel),
    .macro_rd_sel     (macro_rd_sel),
    .macro_addr       (macro_addr),
    .macro_wdata      (macro_wdata),
    .macro_rdata      (macro_rdata),
    .macro_irq        (macro_irq),
    .led_out          (led_out),
    .hash_clock_reset (hash_clock_reset),
    .id_out           (id_out),
    .spi_addr         (spi_addr),
    .irq_out          (irq_out)
  );

  // register-map model state
  logic [5:0]    m_maddr;
  logic [NM-1:0] m_rd_sel, m_wr_sel, m_mask, m_status, m_prev_irq;
  logic [5:0]    m_ctrl;
  logic [7:0]    m_spi;
  logic [31:0]   m_perf, m_snap;
  logic          e_pulse, e_irq_out, e_s1_mac, e_rst;
  logic [NM-1:0] e_wr_sel;
  logic [5:0]    e_waddr, e_s1_addr;
  logic [7:0]    e_wdata;
  int            due_q[$];
  logic [7:0]    data_q[$];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a[7:6] == 2'b10) return {2'b00, a[5:0]} ^ 8'h5A;
    case (a)
      8'h00: v = {2'b00, m_maddr};
      8'h02: v = 8'(m_status);
      8'h03: v = {2'b00, m_ctrl};
      8'h04: v = m_spi;
      8'h05: v = 8'h12;
      8'h06: v = 8'h40;
`ifdef DECRED_PERF_CTR_EN
      8'h07: v = m_perf[7:0];
      8'h08: v = m_snap[15:8];
      8'h09: v = m_snap[23:16];
      8'h0A: v = m_snap[31:24];
`endif
      8'h0B: v = 8'(m_mask);
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // one clock: apply inputs, advance model, check outputs mid-cycle
  task automatic step(input logic rst, input logic wr, input logic rd,
                      input logic [7:0] a, input logic [7:0] d);
    logic [NM-1:0] rise, clr;
    logic          do_rd, exp_v;
    RST = rst; host_wr = wr; host_rd = rd; host_addr = a; host_wdata = d;
    e_rst = rst;
    if (rst) begin
      m_maddr = '0; m_rd_sel = '0; m_wr_sel = '0; m_mask = '0; m_status = '0;
      m_prev_irq = '0; m_ctrl = '0; m_spi = '0; m_perf = '0; m_snap = '0;
      e_pulse = 0; e_irq_out = 0; e_s1_mac = 0; e_wr_sel = '0; e_waddr = '0;
      e_s1_addr = '0; e_wdata = '0;
      due_q.delete(); data_q.delete();
    end else begin
      do_rd = rd && !wr;
      e_irq_out = |(m_status & m_mask);
      e_s1_mac  = do_rd && (a[7:6] == 2'b10);
      e_s1_addr = a[5:0];
      if (do_rd) begin
        due_q.push_back(cyc + 2);
        data_q.push_back(model_read(a));
        if (a == 8'h07) m_snap = m_perf;
      end
      if (wr && a == 8'h03 && d[6]) m_perf = 0;
      else if (m_ctrl[2])           m_perf = m_perf + 1;
      rise = macro_irq & ~m_prev_irq;
      clr  = (wr && a == 8'h0C) ? d[NM-1:0] : '0;
      m_status   = (m_status & ~clr) | rise;
      m_prev_irq = macro_irq;
      e_pulse = 0; e_wr_sel = '0; e_wdata = '0;
      if (wr) begin
        case (a)
          8'h00: m_maddr = d[5:0];
          8'h01: begin
            e_pulse = 1; e_wr_sel = m_wr_sel; e_waddr = m_maddr; e_wdata = d;
            if (m_ctrl[1]) m_maddr = m_maddr + 6'd1;
          end
          8'h02: m_rd_sel = d[NM-1:0];
          8'h03: m_ctrl = d[5:0];
          8'h04: m_spi = d;
          8'h05: m_wr_sel = d[NM-1:0];
          8'h0B: m_mask = d[NM-1:0];
          default: ;
        endcase
      end
    end
    @(posedge M1_CLK);
    cyc++;
    @(negedge M1_CLK);
    exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
    check("rvalid", 32'(host_rvalid), 32'(exp_v));
    if (exp_v) begin
      check("rdata", 32'(host_rdata), 32'(data_q[0]));
      void'(due_q.pop_front());
      void'(data_q.pop_front());
    end
    check("wr_sel", 32'(macro_wr_sel), 32'(e_wr_sel));
    check("wdata", 32'(macro_wdata), 32'(e_wdata));
    if (e_pulse)       check("waddr", 32'(macro_addr), 32'(e_waddr));
    else if (e_s1_mac) check("raddr", 32'(macro_addr), 32'(e_s1_addr));
    else               check("idle_addr", 32'(macro_addr), 32'(m_maddr));
    check("rd_sel", 32'(macro_rd_sel), 32'(m_rd_sel));
    check("irq_out", 32'(irq_out), 32'(e_irq_out));
    check("ctrl_out", 32'({id_out, hash_clock_reset, led_out, macro_hash_en}),
          32'({m_ctrl[5], m_ctrl[4], m_ctrl[3], m_ctrl[0]}));
    check("spi_addr", 32'(spi_addr), 32'(m_spi[6:0]));
    if (e_rst) check("rst_rdata", 32'(host_rdata), 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic rd(input logic [7:0] a);
    step(0, 0, 1, a, 8'h00);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    step(0, 1, 0, a, d);
  endtask

  initial begin
    logic [7:0] ra;
    int         sel;
    macro_irq = '0;
    step(1, 0, 0, 8'h00, 8'h00);
    step(1, 0, 0, 8'h00, 8'h00);

    rd(8'h05); rd(8'h06); rd(8'h03); idle(3);

    wr(8'h05, 8'h05); wr(8'h03, 8'h02); wr(8'h00, 8'h3F);
    wr(8'h01, 8'hAA); wr(8'h01, 8'hBB); rd(8'h00); idle(3);

    wr(8'h02, 8'h02); rd(8'h81); rd(8'h82); idle(3);

    macro_irq = 4'b0100; idle(3); rd(8'h02); idle(3);
    wr(8'h0B, 8'h04); idle(3);
    macro_irq = 4'b0000; idle(1);
    macro_irq = 4'b0100; wr(8'h0C, 8'h04); rd(8'h02); idle(3);
    wr(8'h0C, 8'h04); rd(8'h02); idle(3);

    wr(8'h03, 8'h04); idle(300);
    rd(8'h07); rd(8'h08); rd(8'h09); rd(8'h0A); idle(3);
    wr(8'h03, 8'h44); rd(8'h07); idle(3);
    wr(8'h03, 8'h00);

    step(0, 1, 1, 8'h04, 8'h33); idle(3); rd(8'h04); idle(3);

    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      ra = 8'($urandom_range(0, 13));
      else if (sel < 9) ra = 8'h80 | 8'($urandom_range(0, 63));
      else              ra = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) macro_irq = macro_irq ^ NM'($urandom_range(0, 15));
      step(0, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 5), ra, 8'($urandom));
    end
    idle(3);
    check("drain", 32'(due_q.size()), 32'h0);

    macro_irq = '0;
    wr(8'h03, 8'h3F); rd(8'h81);
    step(1, 0, 0, 8'h00, 8'h00);
    step(1, 0, 0, 8'h00, 8'h00);
    idle(3);
    check("rst_drain", 32'(due_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decred_ctrl_regfile.md
# decred_ctrl_regfile

Parametrised M1_CLK-domain control register file and hash-macro sequencer. It is the next generation of the miner's SPI-facing register bank. It sits between the SPI-to-M1_CLK bridge (single-cycle host strobes) and NUM_MACROS hash macros. Compared with the previous bank, it adds pulsed macro writes with address auto-increment, sticky maskable interrupts with write-1-to-clear, an atomic perf-counter snapshot, and uniform pipelined read latency.

## Interface
- NUM_MACROS, 4, number of hash macros; legal range 1..8.
- DATA_WIDTH, 8, host data width; fixed at 8.
- ADDR_WIDTH, 8, host address width; fixed at 8.
- ID_VALUE, 8'h12, value returned when reading 0x05.
- M1_CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- host_addr  in  ADDR_WIDTH  register address.
- host_wdata  in  DATA_WIDTH  write data.
- host_wr  in  1  single-cycle write strobe.
- host_rd  in  1  single-cycle read strobe.
- host_rdata  out  DATA_WIDTH  read data; valid only while host_rvalid is high.
- host_rvalid  out  1  one-cycle read-data-valid pulse.
- macro_hash_en  out  1  CONTROL.0, registered.
- macro_wr_sel  out  NUM_MACROS  one-cycle write pulse per macro.
- macro_rd_sel  out  NUM_MACROS  read select.
- macro_addr  out  6  macro word address.
- macro_wdata  out  8  macro write data.
- macro_rdata  in  8  shared macro readback; combinational from macro_addr/macro_rd_sel.
- macro_irq  in  NUM_MACROS  macro data-available levels.
- led_out, hash_clock_reset, id_out  out  1 each  CONTROL bits 3, 4, 5.
- spi_addr  out  7  SPI_ADDR[6:0].
- irq_out  out  1  OR of masked sticky status, registered.

## Operation
Register map:
- 0x00 MACRO_ADDR [5:0], read/write.
- 0x01 MACRO_DATA, write-only. Triggers a macro write; see Timing.
- 0x02 write: RD_SEL; read: IRQ_STATUS.
- 0x03 CONTROL, read/write:
  - bit 0 HASH_EN; bit 1 AUTOINC; bit 2 PERF_RUN; bit 3 LED; bit 4 HCLK_RST; bit 5 ID.
  - bit 6 PERF_CLR is self-clearing and always reads 0.
- 0x04 SPI_ADDR, read/write.
- 0x05 write: WR_SEL; read: ID_VALUE.
- 0x06 MACRO_INFO, read-only: {NUM_MACROS[3:0], 4'h0}.
- 0x07–0x0A PERF, read-only, little-endian.
  - Reading 0x07 loads the 32-bit snapshot and returns the live byte 0.
  - 0x08–0x0A return the snapshot bytes.
- 0x0B IRQ_MASK, read/write.
- 0x0C IRQ_CLEAR, write-1-to-clear on IRQ_STATUS; reads 0.
- 0x80–0xBF macro readback at host_addr[5:0] from the macros selected by RD_SEL.
- All other addresses: writes are ignored, reads return 0.

Behaviour:
- Select bits above NUM_MACROS-1 in RD_SEL, WR_SEL, IRQ_MASK and IRQ_STATUS read 0 and are never driven.
- AUTOINC: each MACRO_DATA write increments MACRO_ADDR, wrapping 63→0.
- Interrupts:
  - A rising edge of macro_irq[i] (1-cycle delayed compare) sets IRQ_STATUS[i].
  - A set and a clear of the same bit in the same cycle: set wins.
  - irq_out = |(IRQ_STATUS & IRQ_MASK), registered.
- Perf counter:
  - Increments by 1 per cycle while PERF_RUN=1; wraps at 2^32.
  - PERF_CLR zeroes the counter and wins over the increment in the same cycle.
- host_wr and host_rd in the same cycle: the write is performed, the read is dropped, and no rvalid is issued.

## Timing
- Reset:
  - All registers, counter, snapshot and status are 0.
  - All outputs are 0, including host_rvalid, macro_wr_sel and irq_out.
- Write issued at cycle N: the register value is visible from N+1.
- MACRO_DATA write at cycle N: in cycle N+1, and for that cycle only:
  - macro_wr_sel = WR_SEL;
  - macro_wdata = host_wdata;
  - macro_addr = MACRO_ADDR as it was before any auto-increment.
- Read at cycle N, for every address:
  - N+1: macro_addr/macro_rd_sel are driven for macro reads, and macro_rdata is captured at the end of N+1.
  - N+2: host_rdata is valid and host_rvalid=1 for exactly one cycle.
  - Local-register reads sample at N. A write in N-1 is visible; a write in N is not.
- Back-to-back reads: one per cycle, fully pipelined.
- Idle macro_addr = MACRO_ADDR; idle macro_rd_sel = RD_SEL.
- RST mid-read: reads in flight are discarded and no rvalid is issued.

## Configuration
- DECRED_PERF_CTR_EN defined: the counter, snapshot, PERF_RUN and PERF_CLR are implemented as described.
- DECRED_PERF_CTR_EN undefined:
  - No counter or snapshot flops are built.
  - 0x07–0x0A read 0.
  - CONTROL.2 is still storable and read back, but has no effect.

## Structure
- Shared package decred_regbank_pkg holds:
  - register address localparams;
  - CONTROL bit indices;
  - the macro address width (6);
  - the read-pipeline depth (2).
- One sub-module, decred_irq_ctrl: edge detect, sticky status, W1C, mask, irq_out register; parametrised by NUM_MACROS.

## Test plan
- Reset, then read 0x05, 0x06, 0x03 → 0x12, 0x40, 0x00, each with rvalid exactly 2 cycles after rd.
- WR_SEL=0x05, CONTROL.1=1, MACRO_ADDR=0x3F, two MACRO_DATA writes (0xAA, 0xBB):
  - first pulse: sel=0x5, addr 0x3F, data 0xAA;
  - second pulse: addr 0x00, data 0xBB;
  - MACRO_ADDR then reads 0x01.
- RD_SEL=0x02, model drives macro_rdata = addr^0x5A; back-to-back reads of 0x81 and 0x82 → 0x5B, 0x58 on consecutive cycles.
- macro_irq[2] rises with mask 0 → status 0x04, irq_out 0. Then mask 0x04 → irq_out 1. W1C 0x04 in the same cycle as a new edge on bit 2 → status stays 0x04.
- PERF_RUN for 300 cycles, read 0x07 then 0x08 → snapshot bytes consistent with the counter value at the 0x07 read; PERF_CLR → next 0x07 read is near 0.
- host_wr and host_rd in the same cycle → write is applied, no rvalid. Assert RST during an in-flight read → no rvalid, all outputs 0.
